// File: rtl/sram_slot_sequencer_pkg.sv
// Shared definitions for the SRAM slot sequencer: slot phase encoding and
// the slot length that the phase counter wraps on.
package sram_slot_sequencer_pkg;

  localparam int SLOT_LEN = 6;

  typedef enum logic [2:0] {
    PH_VID_ADDR   = 3'd0,
    PH_VID_HOLD   = 3'd1,
    PH_CPU_ADDR   = 3'd2,
    PH_CPU_WE     = 3'd3,
    PH_CPU_WE_END = 3'd4,
    PH_CPU_DONE   = 3'd5
  } phase_t;

  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt;
    if (int'(ph) >= SLOT_LEN - 1) begin
      nxt = PH_VID_ADDR;
    end else begin
      nxt = phase_t'(ph + 3'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sram_slot_sequencer_if.sv
// Video port, CPU port and SRAM pin bundle of the slot sequencer.
// master = sequencer side, slave = the CPU/video/SRAM environment.
interface sram_slot_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  vid_valid;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  cpu_ack;

  logic [ADDR_WIDTH-1:0] SRAM_ADDR;
  logic                  SRAM_CE1n;
  logic                  SRAM_CE2;
  logic                  SRAM_OEn;
  logic                  SRAM_WEn;
  logic [DATA_WIDTH-1:0] SRAM_DIN;
  logic [DATA_WIDTH-1:0] SRAM_DOUT;
  logic                  SRAM_DOE;

  modport master (
    input  vid_addr,
    output vid_data, vid_valid,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    output SRAM_ADDR, SRAM_CE1n, SRAM_CE2, SRAM_OEn, SRAM_WEn,
    input  SRAM_DIN,
    output SRAM_DOUT, SRAM_DOE
  );

  modport slave (
    output vid_addr,
    input  vid_data, vid_valid,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    input  SRAM_ADDR, SRAM_CE1n, SRAM_CE2, SRAM_OEn, SRAM_WEn,
    output SRAM_DIN,
    input  SRAM_DOUT, SRAM_DOE
  );

endinterface

// File: rtl/sram_slot_sequencer.sv
// Time-multiplexes one asynchronous SRAM between a fixed-rate video read
// slot (phases 0-1) and a CPU read/write slot (phases 2-5); all pins registered.
module sram_slot_sequencer
  import sram_slot_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   RESETn,
  sram_slot_sequencer_if.master  bus
);

  phase_t                phase_r, phase_nxt_s;

  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic                  ce1n_r, ce1n_nxt_s;
  logic                  ce2_r, ce2_nxt_s;
  logic                  oen_r, oen_nxt_s;
  logic                  wen_r, wen_nxt_s;
  logic                  doe_r, doe_nxt_s;
  logic [DATA_WIDTH-1:0] dout_r, dout_nxt_s;

  logic [DATA_WIDTH-1:0] vid_data_r, vid_data_nxt_s;
  logic                  vid_valid_r, vid_valid_nxt_s;
  logic [DATA_WIDTH-1:0] cpu_dout_r, cpu_dout_nxt_s;
  logic                  cpu_ack_r, cpu_ack_nxt_s;

  // CPU request captured at the phase-2 sampling edge, qualifying phases 3-5
  logic                  cpu_act_r, cpu_act_nxt_s;
  logic                  cpu_we_r, cpu_we_nxt_s;

  // Next-state and next-pin computation, keyed on the phase being entered
  always_comb begin
    phase_nxt_s     = next_phase(phase_r);
    addr_nxt_s      = addr_r;
    ce1n_nxt_s      = ce1n_r;
    ce2_nxt_s       = ce2_r;
    oen_nxt_s       = oen_r;
    wen_nxt_s       = wen_r;
    doe_nxt_s       = doe_r;
    dout_nxt_s      = dout_r;
    vid_data_nxt_s  = vid_data_r;
    vid_valid_nxt_s = 1'b0;
    cpu_dout_nxt_s  = cpu_dout_r;
    cpu_ack_nxt_s   = 1'b0;
    cpu_act_nxt_s   = cpu_act_r;
    cpu_we_nxt_s    = cpu_we_r;

    case (phase_nxt_s)
      PH_VID_ADDR: begin
        addr_nxt_s = bus.vid_addr;
        ce1n_nxt_s = 1'b0;
        ce2_nxt_s  = 1'b1;
        oen_nxt_s  = 1'b0;
        wen_nxt_s  = 1'b1;
        doe_nxt_s  = 1'b0;
      end

      PH_VID_HOLD: begin
        wen_nxt_s = 1'b1;
      end

      PH_CPU_ADDR: begin
        vid_data_nxt_s  = bus.SRAM_DIN;
        vid_valid_nxt_s = 1'b1;
        cpu_act_nxt_s   = bus.cpu_req;
        cpu_we_nxt_s    = bus.cpu_we;
        wen_nxt_s       = 1'b1;
        if (bus.cpu_req) begin
          addr_nxt_s = bus.cpu_addr;
          ce1n_nxt_s = 1'b0;
          ce2_nxt_s  = 1'b1;
          // OEn and DOE switch on the same edge, so they never overlap
          if (bus.cpu_we) begin
            oen_nxt_s  = 1'b1;
            doe_nxt_s  = 1'b1;
            dout_nxt_s = bus.cpu_din;
          end else begin
            oen_nxt_s  = 1'b0;
            doe_nxt_s  = 1'b0;
          end
        end else begin
          ce1n_nxt_s = 1'b1;
          ce2_nxt_s  = 1'b0;
          oen_nxt_s  = 1'b1;
          doe_nxt_s  = 1'b0;
        end
      end

      PH_CPU_WE: begin
        if (cpu_act_r && cpu_we_r) begin
          wen_nxt_s = 1'b0;
        end else begin
          wen_nxt_s = 1'b1;
        end
      end

      PH_CPU_WE_END: begin
        // WEn rises here while address and data stay put
        wen_nxt_s = 1'b1;
      end

      PH_CPU_DONE: begin
        if (cpu_act_r) begin
          cpu_ack_nxt_s = 1'b1;
          if (cpu_we_r) begin
            doe_nxt_s  = 1'b0;
            ce1n_nxt_s = 1'b1;
            ce2_nxt_s  = 1'b0;
            oen_nxt_s  = 1'b1;
          end else begin
            cpu_dout_nxt_s = bus.SRAM_DIN;
          end
        end else begin
          wen_nxt_s = 1'b1;
        end
      end

      default: begin
        ce1n_nxt_s    = 1'b1;
        ce2_nxt_s     = 1'b0;
        oen_nxt_s     = 1'b1;
        wen_nxt_s     = 1'b1;
        doe_nxt_s     = 1'b0;
        cpu_act_nxt_s = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset parks the SRAM disabled with WEn high
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      phase_r     <= PH_VID_ADDR;
      addr_r      <= '0;
      ce1n_r      <= 1'b1;
      ce2_r       <= 1'b0;
      oen_r       <= 1'b1;
      wen_r       <= 1'b1;
      doe_r       <= 1'b0;
      dout_r      <= '0;
      vid_data_r  <= '0;
      vid_valid_r <= 1'b0;
      cpu_dout_r  <= '0;
      cpu_ack_r   <= 1'b0;
      cpu_act_r   <= 1'b0;
      cpu_we_r    <= 1'b0;
    end else begin
      phase_r     <= phase_nxt_s;
      addr_r      <= addr_nxt_s;
      ce1n_r      <= ce1n_nxt_s;
      ce2_r       <= ce2_nxt_s;
      oen_r       <= oen_nxt_s;
      wen_r       <= wen_nxt_s;
      doe_r       <= doe_nxt_s;
      dout_r      <= dout_nxt_s;
      vid_data_r  <= vid_data_nxt_s;
      vid_valid_r <= vid_valid_nxt_s;
      cpu_dout_r  <= cpu_dout_nxt_s;
      cpu_ack_r   <= cpu_ack_nxt_s;
      cpu_act_r   <= cpu_act_nxt_s;
      cpu_we_r    <= cpu_we_nxt_s;
    end
  end

  assign bus.SRAM_ADDR = addr_r;
  assign bus.SRAM_CE1n = ce1n_r;
  assign bus.SRAM_CE2  = ce2_r;
  assign bus.SRAM_OEn  = oen_r;
  assign bus.SRAM_WEn  = wen_r;
  assign bus.SRAM_DOE  = doe_r;
  assign bus.SRAM_DOUT = dout_r;
  assign bus.vid_data  = vid_data_r;
  assign bus.vid_valid = vid_valid_r;
  assign bus.cpu_dout  = cpu_dout_r;
  assign bus.cpu_ack   = cpu_ack_r;

endmodule

// File: tb/tb_sram_slot_sequencer.sv
// Bench for sram_slot_sequencer: SRAM device model, slot-level reference model,
// access table, directed corner sequences and a randomized CPU/video phase.
module tb_sram_slot_sequencer;

  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int SLOT = 6;
  localparam logic [7:0] FLOAT = 8'hEE;

  logic clk;
  logic RESETn;
  logic load;

  sram_slot_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  sram_slot_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] v;
    if (i == 32'h123) v = 8'hA5;
    else              v = 8'(i) ^ 8'h3C;
    return v;
  endfunction

  // SRAM device: write latched when WEn rises with chip and driver enabled
  logic [7:0] sram_mem [0:1023];
  always @(posedge bus.SRAM_WEn or posedge load) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= init_byte(i);
    end else if (!bus.SRAM_CE1n && bus.SRAM_CE2 && bus.SRAM_DOE) begin
      sram_mem[bus.SRAM_ADDR] <= bus.SRAM_DOUT;
    end
  end
  assign bus.SRAM_DIN = (!bus.SRAM_CE1n && bus.SRAM_CE2 && !bus.SRAM_OEn) ?
                        sram_mem[bus.SRAM_ADDR] : FLOAT;

  // Reference model state (slot-level view of the memory and the ports)
  logic [7:0] ref_mem [0:1023];
  int         ph;
  logic       vid_seen, pend, pend_we;
  logic [9:0] vaddr_m, pend_a;
  logic [7:0] pend_d, exp_vdata, exp_dout;
  logic       exp_valid, exp_ack;
  logic       prev_wen;
  logic [9:0] prev_addr;

  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph        = 0;
    vid_seen  = 1'b0;
    pend      = 1'b0;
    pend_we   = 1'b0;
    exp_vdata = 8'h00;
    exp_dout  = 8'h00;
    prev_wen  = 1'b1;
    prev_addr = 10'h000;
  endtask

  // One clock: advance the model at the edge, compare outputs half a cycle later
  task automatic step();
    @(posedge clk);
    ph        = (ph + 1) % SLOT;
    exp_valid = 1'b0;
    exp_ack   = 1'b0;
    if (ph == 0) begin
      vaddr_m  = bus.vid_addr;
      vid_seen = 1'b1;
    end
    if (ph == 2) begin
      exp_valid = 1'b1;
      exp_vdata = vid_seen ? ref_mem[vaddr_m] : FLOAT;
      pend      = bus.cpu_req;
      pend_we   = bus.cpu_we;
      pend_a    = bus.cpu_addr;
      pend_d    = bus.cpu_din;
    end
    if (ph == 5 && pend) begin
      exp_ack = 1'b1;
      if (pend_we) ref_mem[pend_a] = pend_d;
      else         exp_dout = ref_mem[pend_a];
      pend = 1'b0;
    end
    @(negedge clk);
    chk("vid_valid", 32'(bus.vid_valid), 32'(exp_valid));
    chk("vid_data",  32'(bus.vid_data),  32'(exp_vdata));
    chk("cpu_ack",   32'(bus.cpu_ack),   32'(exp_ack));
    chk("cpu_dout",  32'(bus.cpu_dout),  32'(exp_dout));
    chk("doe_vs_oen", 32'(bus.SRAM_DOE & ~bus.SRAM_OEn), 32'd0);
    if (!prev_wen && bus.SRAM_WEn) chk("addr_at_wen_rise", 32'(bus.SRAM_ADDR), 32'(prev_addr));
    prev_wen  = bus.SRAM_WEn;
    prev_addr = bus.SRAM_ADDR;
  endtask

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
    int         raise_ph;
    int         lat;
  } acc_t;

  acc_t tbl [7];

  // Raise a request in a chosen phase and check latency, write pulse and read data
  task automatic run_access(input acc_t v);
    int lat;
    int wl;
    bit got;
    while (ph != v.raise_ph) step();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = v.we;
    bus.cpu_addr = v.addr;
    bus.cpu_din  = v.din;
    lat = 0;
    wl  = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      lat++;
      if (!bus.SRAM_WEn) begin
        wl++;
        chk("wr_addr", 32'(bus.SRAM_ADDR), 32'(v.addr));
        chk("wr_data", 32'(bus.SRAM_DOUT), 32'(v.din));
      end
      if (bus.cpu_ack) got = 1'b1;
    end
    bus.cpu_req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(lat), 32'(v.lat));
    if (v.we) chk("we_pulse_len", 32'(wl), 32'd1);
    else      chk("rd_data", 32'(bus.cpu_dout), 32'(v.exp));
  endtask

  initial begin
    int   cnt;
    int   lat;
    bit   got;
    logic [7:0] orig, m;

    n_cmp = 0;
    n_err = 0;
    RESETn = 1'b0;
    load   = 1'b0;
    bus.vid_addr = 10'h000;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h000;
    bus.cpu_din  = 8'h00;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    model_reset();
    #1 load = 1'b1;
    #1 load = 1'b0;

    tbl[0] = '{we: 1'b1, addr: 10'h010, din: 8'h5A, exp: 8'h00, raise_ph: 2, lat: 9};
    tbl[1] = '{we: 1'b0, addr: 10'h010, din: 8'h00, exp: 8'h5A, raise_ph: 1, lat: 4};
    tbl[2] = '{we: 1'b1, addr: 10'h3FF, din: 8'hC3, exp: 8'h00, raise_ph: 5, lat: 6};
    tbl[3] = '{we: 1'b0, addr: 10'h3FF, din: 8'h00, exp: 8'hC3, raise_ph: 0, lat: 5};
    tbl[4] = '{we: 1'b1, addr: 10'h000, din: 8'hFF, exp: 8'h00, raise_ph: 3, lat: 8};
    tbl[5] = '{we: 1'b0, addr: 10'h000, din: 8'h00, exp: 8'hFF, raise_ph: 4, lat: 7};
    tbl[6] = '{we: 1'b0, addr: 10'h123, din: 8'h00, exp: 8'hA5, raise_ph: 2, lat: 9};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_addr",  32'(bus.SRAM_ADDR), 32'd0);
    chk("rst_ce1n",  32'(bus.SRAM_CE1n), 32'd1);
    chk("rst_ce2",   32'(bus.SRAM_CE2),  32'd0);
    chk("rst_oen",   32'(bus.SRAM_OEn),  32'd1);
    chk("rst_wen",   32'(bus.SRAM_WEn),  32'd1);
    chk("rst_doe",   32'(bus.SRAM_DOE),  32'd0);
    chk("rst_dout",  32'(bus.SRAM_DOUT), 32'd0);
    chk("rst_vdata", 32'(bus.vid_data),  32'd0);
    chk("rst_vvalid", 32'(bus.vid_valid), 32'd0);
    chk("rst_cdout", 32'(bus.cpu_dout),  32'd0);
    chk("rst_ack",   32'(bus.cpu_ack),   32'd0);
    bus.vid_addr = 10'h123;
    RESETn = 1'b1;

    // Video only: a valid pulse every slot, chip idle through the CPU half
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (bus.vid_valid) cnt++;
      if (ph >= 2) chk("ce_idle", 32'({bus.SRAM_CE1n, bus.SRAM_CE2}), 32'b10);
    end
    chk("vid_pulse_count", 32'(cnt), 32'd4);
    chk("vid_a5", 32'(bus.vid_data), 32'hA5);

    // Write 0x010, then confirm through the video port and a CPU read
    run_access(tbl[0]);
    bus.vid_addr = 10'h010;
    repeat (12) step();
    chk("vid_after_wr", 32'(bus.vid_data), 32'h5A);
    run_access(tbl[1]);
    chk("vid_unaffected", 32'(bus.vid_data), 32'h5A);
    for (int i = 2; i < 7; i++) run_access(tbl[i]);

    // Back-to-back: request held across the ack starts the next slot's access
    while (ph != 2) step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h2AA; bus.cpu_din = 8'h11;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin step(); got = bus.cpu_ack; end
    chk("b2b_first_ack", 32'(got), 32'd1);
    bus.cpu_we = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin step(); lat++; got = bus.cpu_ack; end
    bus.cpu_req = 1'b0;
    chk("b2b_second_ack", 32'(got), 32'd1);
    chk("b2b_latency", 32'(lat), 32'd6);
    chk("b2b_rd_data", 32'(bus.cpu_dout), 32'h11);

    // Reset in the middle of a write pulse
    while (ph != 1) step();
    orig = ref_mem[10'h200];
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h200; bus.cpu_din = 8'h77;
    step();
    step();
    chk("abort_wen_low", 32'(bus.SRAM_WEn), 32'd0);
    RESETn = 1'b0;
    #1;
    chk("abort_wen",  32'(bus.SRAM_WEn),  32'd1);
    chk("abort_doe",  32'(bus.SRAM_DOE),  32'd0);
    chk("abort_ce1n", 32'(bus.SRAM_CE1n), 32'd1);
    chk("abort_ce2",  32'(bus.SRAM_CE2),  32'd0);
    bus.cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(bus.cpu_ack), 32'd0);
    end
    RESETn = 1'b1;
    model_reset();
    m = sram_mem[10'h200];
    $display("INFO mem[0x200] after aborted write = 0x%0h (before 0x%0h)", m, orig);
    chk("abort_mem", 32'((m == orig) || (m == 8'h77)), 32'd1);
    ref_mem[10'h200] = m;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_ack_after", 32'(bus.cpu_ack), 32'd0);
    end

    // Randomized CPU and video traffic against the reference model
    for (int c = 0; c < 900; c++) begin
      if (bus.cpu_ack || !bus.cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.cpu_req  = 1'b1;
          bus.cpu_we   = 1'($urandom_range(0, 1));
          bus.cpu_addr = 10'($urandom_range(0, 1023));
          bus.cpu_din  = 8'($urandom_range(0, 255));
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
      if ($urandom_range(0, 4) == 0) bus.vid_addr = 10'($urandom_range(0, 1023));
      step();
    end
    bus.cpu_req = 1'b0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
